// File: rtl/prmcu_uart_rx_fifo.sv
// UART receive path: 2-flop synchronizer, oversampled majority-vote receiver with a
// runtime frame format, and a first-word-fall-through FIFO with sticky overrun.
module prmcu_uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx_en,
    input  logic [3:0]                        n_data_bits_i,
    input  logic [1:0]                        parity_mode_i,
    input  logic [1:0]                        n_stop_bits_i,
    input  logic [DIV_W-1:0]                  baud_div_i,
    input  logic                              rx_i,
    output logic [8:0]                        out_dat_o,
    output logic [2:0]                        out_err_o,
    output logic                              out_vld_o,
    input  logic                              out_rdy_i,
    output logic                              overrun_o,
    input  logic                              clr_ovr_i,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
    output logic [2:0]                        dbg_state_o
);

    localparam int HALF = OVERSAMPLE / 2;
    localparam int OSW  = $clog2(OVERSAMPLE);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] SMP0    = OSW'(HALF - 1);
    localparam logic [OSW-1:0] SMP1    = OSW'(HALF);
    localparam logic [OSW-1:0] SMP2    = OSW'(HALF + 1);
    localparam logic [LW-1:0]  FULL_LVL = LW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic             rx_s1, rx_s2, rx_prev;
    logic [2:0]       state;
    logic [DIV_W-1:0] div_q, div_cnt, div_m;
    logic [OSW-1:0]   os_cnt;
    logic [3:0]       nd_q, bit_cnt;
    logic             par_en_q, par_odd_q, stop2_q, stop_cnt;
    logic             samp0, samp1;
    logic [8:0]       data_sr;
    logic             par_acc, all_zero, par_err, frm_err;

    logic             start_edge, in_frame, tick, decide, maj, last_stop, push;
    logic [11:0]      push_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_comb begin
        start_edge = (state == S_IDLE) & rx_en & rx_prev & ~rx_s2;
        in_frame   = (state == S_START) | (state == S_DATA) |
                     (state == S_PARITY) | (state == S_STOP);
        div_m      = (div_q == '0) ? DIV_W'(1) : div_q;
        tick       = in_frame & (div_cnt == div_m - DIV_W'(1));
        decide     = tick & (os_cnt == SMP2);
        // Third vote is the live sample taken on the decision tick itself.
        maj        = (samp0 & samp1) | (samp0 & rx_s2) | (samp1 & rx_s2);
        last_stop  = ~stop2_q | stop_cnt;
        push       = rx_en & decide & (state == S_STOP) & last_stop;
        push_word  = {all_zero & ~maj, frm_err | ~maj, par_err, data_sr};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            div_q     <= '0;
            div_cnt   <= '0;
            os_cnt    <= '0;
            nd_q      <= 4'd8;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_cnt  <= 1'b0;
            samp0     <= 1'b1;
            samp1     <= 1'b1;
            data_sr   <= '0;
            par_acc   <= 1'b0;
            all_zero  <= 1'b1;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
        end else if (!rx_en) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state     <= S_START;
                        div_q     <= baud_div_i;
                        div_cnt   <= '0;
                        os_cnt    <= '0;
                        nd_q      <= (n_data_bits_i >= 4'd5 && n_data_bits_i <= 4'd9) ?
                                     n_data_bits_i : 4'd8;
                        par_en_q  <= (parity_mode_i == 2'd1) | (parity_mode_i == 2'd2);
                        par_odd_q <= (parity_mode_i == 2'd2);
                        stop2_q   <= (n_stop_bits_i >= 2'd2);
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        data_sr   <= '0;
                        par_acc   <= 1'b0;
                        all_zero  <= 1'b1;
                        par_err   <= 1'b0;
                        frm_err   <= 1'b0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s2) state <= S_IDLE;
                end
                default: begin
                    if (tick) begin
                        div_cnt <= '0;
                        os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OSW'(1);
                        if (os_cnt == SMP0) samp0 <= rx_s2;
                        if (os_cnt == SMP1) samp1 <= rx_s2;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                    if (decide) begin
                        case (state)
                            S_START: state <= maj ? S_IDLE : S_DATA;
                            S_DATA: begin
                                data_sr[bit_cnt] <= maj;
                                par_acc          <= par_acc ^ maj;
                                all_zero         <= all_zero & ~maj;
                                bit_cnt          <= bit_cnt + 4'd1;
                                if (bit_cnt == nd_q - 4'd1)
                                    state <= par_en_q ? S_PARITY : S_STOP;
                            end
                            S_PARITY: begin
                                par_err  <= (maj != (par_odd_q ? ~par_acc : par_acc));
                                all_zero <= all_zero & ~maj;
                                state    <= S_STOP;
                            end
                            default: begin
                                if (!maj) frm_err <= 1'b1;
                                all_zero <= all_zero & ~maj;
                                if (last_stop) state <= maj ? S_IDLE : S_WAIT_HIGH;
                                else           stop_cnt <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          ovr, pop, full, push_ok;
    logic [11:0]   head;

    always_comb begin
        pop     = (level != '0) & out_rdy_i;
        full    = (level == FULL_LVL);
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        push_ok = push & (~full | pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovr    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push & ~push_ok) ovr <= 1'b1;
            else if (clr_ovr_i)  ovr <= 1'b0;
        end
    end

    assign out_dat_o    = head[8:0];
    assign out_err_o    = head[11:9];
    assign out_vld_o    = (level != '0);
    assign fifo_level_o = level;
    assign overrun_o    = ovr;
    assign busy_o       = (state != S_IDLE);
    assign dbg_state_o  = state;

endmodule

// File: tb/tb_prmcu_uart_rx_fifo.sv
// Randomized and directed frames against a frame-level reference model; a monitor
// pops every word the DUT hands out and compares it with the expected queue.
module tb_prmcu_uart_rx_fifo;

    localparam int OS    = 16;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          rx_en;
    logic [3:0]    n_data_bits_i;
    logic [1:0]    parity_mode_i;
    logic [1:0]    n_stop_bits_i;
    logic [15:0]   baud_div_i;
    logic          rx_i;
    logic [8:0]    out_dat_o;
    logic [2:0]    out_err_o;
    logic          out_vld_o;
    logic          out_rdy_i;
    logic          overrun_o;
    logic          clr_ovr_i;
    logic          busy_o;
    logic [LW-1:0] fifo_level_o;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    prmcu_uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en),
        .n_data_bits_i(n_data_bits_i), .parity_mode_i(parity_mode_i),
        .n_stop_bits_i(n_stop_bits_i), .baud_div_i(baud_div_i), .rx_i(rx_i),
        .out_dat_o(out_dat_o), .out_err_o(out_err_o), .out_vld_o(out_vld_o),
        .out_rdy_i(out_rdy_i), .overrun_o(overrun_o), .clr_ovr_i(clr_ovr_i),
        .busy_o(busy_o), .fifo_level_o(fifo_level_o), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model + driver. mode 0: expect word if room, 1: expect word
    // unconditionally, 2: frame is expected to be discarded.
    task automatic send_frame(input logic [8:0] d, input int nb_cfg, input int pm,
                              input int ns_cfg, input bit flip, input bit stop_v,
                              input int div, input int mode);
        int nb, ns, de, bt;
        bit pen, pexp, pbit, perr, ferr, brk;
        logic [8:0] dm;
        nb   = (nb_cfg >= 5 && nb_cfg <= 9) ? nb_cfg : 8;
        ns   = (ns_cfg >= 2) ? 2 : 1;
        de   = (div == 0) ? 1 : div;
        bt   = OS * de;
        pen  = (pm == 1) || (pm == 2);
        dm   = d & 9'((1 << nb) - 1);
        pexp = (pm == 2) ? ~(^dm) : ^dm;
        pbit = pexp ^ flip;
        perr = pen && (pbit != pexp);
        ferr = !stop_v;
        brk  = (dm == 9'd0) && (!pen || !pbit) && !stop_v;
        if (mode == 1 || (mode == 0 && exp_q.size() < DEPTH))
            exp_q.push_back({brk, ferr, perr, dm});
        n_data_bits_i = 4'(nb_cfg);
        parity_mode_i = 2'(pm);
        n_stop_bits_i = 2'(ns_cfg);
        baud_div_i    = 16'(div);
        wait_clks(1);
        rx_i = 1'b0;
        wait_clks(bt);
        for (int i = 0; i < nb; i++) begin
            rx_i = dm[i];
            wait_clks(bt);
        end
        if (pen) begin
            rx_i = pbit;
            wait_clks(bt);
        end
        for (int i = 0; i < ns; i++) begin
            rx_i = stop_v;
            wait_clks(bt);
        end
        rx_i = 1'b1;
        wait_clks(bt);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_clks(1);
        chk(name, exp_q.size(), 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && out_vld_o && out_rdy_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word: unexpected word err=%b dat=0x%0h", out_err_o, out_dat_o);
            end else begin
                chk("word", {20'd0, out_err_o, out_dat_o}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [8:0] d;
        rst = 1'b0; rx_en = 1'b1; rx_i = 1'b1; out_rdy_i = 1'b1; clr_ovr_i = 1'b0;
        n_data_bits_i = 4'd8; parity_mode_i = 2'd0; n_stop_bits_i = 2'd1; baud_div_i = 16'd4;
        wait_clks(3);
        chk("rst_vld", out_vld_o, 0);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_ovr", overrun_o, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b1;
        wait_clks(2);

        // 8N1 basic bytes
        send_frame(9'h55, 8, 0, 1, 0, 1, 4, 0);
        send_frame(9'hA3, 8, 0, 1, 0, 1, 4, 0);
        send_frame(9'h00, 8, 0, 1, 0, 1, 4, 0);
        send_frame(9'hFF, 8, 0, 1, 0, 1, 4, 0);
        wait_drain("drain_8n1");
        chk("ovr_8n1", overrun_o, 0);

        // 9 bits, 2 stop, even then odd parity with the same parity bit values
        send_frame(9'h1A5, 9, 1, 2, 0, 1, 4, 0);
        send_frame(9'h1A5, 9, 1, 2, 1, 1, 4, 0);
        send_frame(9'h1A5, 9, 2, 2, 1, 1, 4, 0);
        send_frame(9'h1A5, 9, 2, 2, 0, 1, 4, 0);
        wait_drain("drain_par");

        // framing error, then a long break
        send_frame(9'h3C, 8, 0, 1, 0, 0, 4, 0);
        wait_drain("drain_frm");
        n_data_bits_i = 4'd8; parity_mode_i = 2'd0; n_stop_bits_i = 2'd1; baud_div_i = 16'd4;
        exp_q.push_back({3'b110, 9'h000});
        wait_clks(1);
        rx_i = 1'b0;
        wait_clks(20 * OS * 4);
        chk("brk_busy_low", busy_o, 1);
        chk("brk_one_word", exp_q.size(), 0);
        rx_i = 1'b1;
        wait_clks(2 * OS * 4);
        chk("brk_idle", busy_o, 0);
        chk("brk_level", fifo_level_o, 0);

        // glitch shorter than half a bit
        rx_i = 1'b0;
        wait_clks(3 * 4);
        rx_i = 1'b1;
        chk("glitch_busy", busy_o, 1);
        wait_clks(OS * 4);
        chk("glitch_idle", busy_o, 0);
        chk("glitch_level", fifo_level_o, 0);

        // random formats
        for (int i = 0; i < 20; i++) begin
            d = 9'($urandom_range(0, 511));
            send_frame(d, $urandom_range(4, 10), $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       $urandom_range(0, 3), 0);
        end
        wait_drain("drain_rand");

        // overflow with the consumer stalled
        out_rdy_i = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++)
            send_frame(9'($urandom_range(0, 255)), 8, 0, 1, 0, 1, 4, 0);
        chk("full_level", fifo_level_o, DEPTH);
        chk("full_ovr", overrun_o, 1);
        clr_ovr_i = 1'b1;
        wait_clks(1);
        clr_ovr_i = 1'b0;
        chk("clr_ovr", overrun_o, 0);
        // push lands at 3 + (9*OS + OS/2 + 2) * div clocks after the start edge drive
        fork
            send_frame(9'h96, 8, 0, 1, 0, 1, 4, 1);
            begin
                wait_clks(1 + 3 + (9 * OS + OS / 2 + 2) * 4 - 1);
                out_rdy_i = 1'b1;
                wait_clks(1);
                out_rdy_i = 1'b0;
            end
        join
        chk("pushpop_ovr", overrun_o, 0);
        chk("pushpop_level", fifo_level_o, DEPTH);
        out_rdy_i = 1'b1;
        wait_drain("drain_full");
        chk("empty_level", fifo_level_o, 0);

        // receiver disabled mid-frame
        fork
            send_frame(9'hFF, 8, 0, 1, 0, 1, 4, 2);
            begin
                wait_clks(1 + 3 * OS * 4 + 20);
                rx_en = 1'b0;
                wait_clks(2);
                rx_en = 1'b1;
            end
        join
        chk("en_drop_busy", busy_o, 0);
        chk("en_drop_level", fifo_level_o, 0);
        send_frame(9'h5A, 8, 0, 1, 0, 1, 4, 0);
        wait_drain("drain_en");

        // reset mid-frame with words queued
        out_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++)
            send_frame(9'($urandom_range(0, 255)), 8, 0, 1, 0, 1, 4, 0);
        chk("queued_level", fifo_level_o, 3);
        fork
            send_frame(9'hFF, 8, 0, 1, 0, 1, 4, 2);
            begin
                wait_clks(1 + 2 * OS * 4 + 10);
                rst = 1'b0;
                wait_clks(1);
                chk("mid_rst_level", fifo_level_o, 0);
                chk("mid_rst_vld", out_vld_o, 0);
                chk("mid_rst_busy", busy_o, 0);
                exp_q.delete();
                rst = 1'b1;
            end
        join
        out_rdy_i = 1'b1;
        send_frame(9'hC3, 8, 0, 1, 0, 1, 4, 0);
        wait_drain("drain_final");
        chk("final_ovr", overrun_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
